// File: rtl/fibo_pkg.sv
// Shared definitions for the sequential Fibonacci engine:
// the controller state encoding and the default datapath widths.
package fibo_pkg;

    localparam int FIBO_IN_W  = 5;
    localparam int FIBO_OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fibo_state_e;

endpackage : fibo_pkg

// File: rtl/fibonacci_calculator_if.sv
// Start/done handshake between a requester and the Fibonacci engine.
interface fibonacci_calculator_if
    import fibo_pkg::*;
#(
    parameter int IN_W  = FIBO_IN_W,
    parameter int OUT_W = FIBO_OUT_W
);

    logic [IN_W-1:0]  input_s;
    logic             begin_fibo;
    logic             done;
    logic [OUT_W-1:0] fibo_out;

    modport master (
        output input_s,
        output begin_fibo,
        input  done,
        input  fibo_out
    );

    modport slave (
        input  input_s,
        input  begin_fibo,
        output done,
        output fibo_out
    );

endinterface : fibonacci_calculator_if

// File: rtl/fibonacci_calculator.sv
// Iterative Fibonacci engine: a rising edge on begin_fibo latches n and the
// result F(n) mod 2^OUT_W appears on fibo_out with done held high.
module fibonacci_calculator
    import fibo_pkg::*;
#(
    parameter int IN_W  = FIBO_IN_W,
    parameter int OUT_W = FIBO_OUT_W
)
(
    input  logic                  clk,
    input  logic                  reset,
    fibonacci_calculator_if.slave bus
);

    fibo_state_e       r_state;
    logic [OUT_W-1:0]  r_a;
    logic [OUT_W-1:0]  r_b;
    logic [IN_W-1:0]   r_cnt;
    logic              r_begin_d;
    logic              r_done;
    logic [OUT_W-1:0]  r_fibo_out;

    logic              w_start;
    logic [OUT_W-1:0]  w_sum;

    // Start edge detection and the truncating adder.
    always_comb begin
        w_start = bus.begin_fibo & ~r_begin_d;
        w_sum   = r_a + r_b;
    end

    // Controller and datapath; a new start is honoured from IDLE and DONE alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= {OUT_W{1'b0}};
            r_b        <= OUT_W'(1'b1);
            r_cnt      <= {IN_W{1'b0}};
            r_begin_d  <= 1'b0;
            r_done     <= 1'b0;
            r_fibo_out <= {OUT_W{1'b0}};
        end else begin
            r_begin_d <= bus.begin_fibo;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_a        <= {OUT_W{1'b0}};
                        r_b        <= OUT_W'(1'b1);
                        r_cnt      <= bus.input_s;
                        r_done     <= 1'b0;
                        r_fibo_out <= {OUT_W{1'b0}};
                        r_state    <= CALC;
                    end else begin
                        r_state <= r_state;
                    end
                end
                CALC: begin
                    // a tracks F(n-cnt); once cnt reaches zero it is the answer.
                    if (r_cnt == {IN_W{1'b0}}) begin
                        r_fibo_out <= r_a;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_a   <= r_b;
                        r_b   <= w_sum;
                        r_cnt <= r_cnt - IN_W'(1'b1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_fibo_out <= {OUT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.done     = r_done;
    assign bus.fibo_out = r_fibo_out;

endmodule : fibonacci_calculator

// File: tb/tb_fibonacci_calculator.sv
// Self-checking bench for fibonacci_calculator: directed scenarios plus
// randomized indices and start-pulse lengths against an arithmetic reference.
module tb_fibonacci_calculator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fibonacci_calculator_if #(.IN_W(5), .OUT_W(16)) bus ();

    fibonacci_calculator #(.IN_W(5), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned fib_ref(input int n);
        int unsigned seq [0:31];
        seq[0] = 0;
        seq[1] = 1;
        for (int k = 2; k <= 31; k++) seq[k] = (seq[k-1] + seq[k-2]) % 65536;
        return seq[n];
    endfunction

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a computation with begin_fibo held for 'hold' sampled edges.
    task automatic run_fib(input int n, input int hold, input string tag);
        int          lat;
        int unsigned exp;
        exp = fib_ref(n);
        bus.input_s    = n[4:0];
        bus.begin_fibo = 1'b1;
        tick();
        check_eq({tag, "_start_clr"}, bus.done, 0);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (1 + lat >= hold) bus.begin_fibo = 1'b0;
            bus.input_s = 5'($urandom);
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, n + 1);
        check_eq({tag, "_value"}, bus.fibo_out, exp);
        for (int s = 0; s < 4; s++) begin
            if (1 + lat + s >= hold) bus.begin_fibo = 1'b0;
            tick();
            check_eq({tag, "_hold_done"}, bus.done, 1);
            check_eq({tag, "_hold_val"}, bus.fibo_out, exp);
        end
        bus.begin_fibo = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int hold;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.input_s = 5'd0;
        bus.begin_fibo = 1'b0;
        tick();
        tick();
        check_eq("reset_done", bus.done, 0);
        check_eq("reset_out", bus.fibo_out, 0);
        reset = 1'b0;
        tick();
        check_eq("idle_done", bus.done, 0);

        run_fib(5, 2, "n5");
        run_fib(9, 2, "n9");
        run_fib(12, 2, "n12");
        run_fib(18, 2, "n18");
        run_fib(0, 1, "n0");
        run_fib(1, 1, "n1");
        run_fib(3, 5, "level_hold");

        // Reset in the middle of a long run abandons it.
        bus.input_s = 5'd20;
        bus.begin_fibo = 1'b1;
        tick();
        bus.begin_fibo = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("midreset_done", bus.done, 0);
        check_eq("midreset_out", bus.fibo_out, 0);
        reset = 1'b0;
        tick();
        run_fib(6, 1, "after_reset");

        run_fib(24, 1, "n24");
        run_fib(25, 1, "overflow");
        run_fib(7, 1, "back2back");
        run_fib(31, 3, "n31");

        for (int t = 0; t < 12; t++) begin
            n    = int'($urandom_range(0, 31));
            hold = int'($urandom_range(1, n + 5));
            run_fib(n, hold, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fibonacci_calculator
